mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Target side of the core's memory bus: accepts data reads, data writes and
//  32-bit instruction fetches from the cpu, runs them on a pipelined 16-bit
//  synchronous backing RAM, and returns busy/cack/ready plus read data.
//  Sits between the cpu and the on-board RAM in place of the external
//  controller.
// PARAMETERS
//  LATENCY  2   backing RAM read latency in cycles, >=1 (rdata valid LATENCY cycles after mem_re)
//  MEM_AW   18  backing RAM halfword address width (fixed map below requires 18)
// PORTS
//  clk           in   1   clock
//  rst           in   1   async reset, active-high
//  addr          in   16  cpu address (data word address or instruction index)
//  wdata         in   16  cpu write data
//  read          in   1   read request
//  write         in   1   write request
//  instr_access  in   1   1 = instruction space
//  read_done     in   1   cpu has consumed read data
//  mem_bus       out  16  data read result (registered)
//  instr         out  32  instruction fetch result (registered)
//  busy          out  1   transaction in progress
//  cack          out  1   one-cycle command-accepted pulse
//  ready         out  1   read data valid / write complete
//  err           out  1   sticky: instruction-space write attempted
//  mem_addr      out  18  backing RAM address
//  mem_wdata     out  16  backing RAM write data
//  mem_we        out  1   backing RAM write strobe
//  mem_re        out  1   backing RAM read strobe
//  mem_rdata     in   16  backing RAM read data
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; every output 0, including mem_bus, instr
//    and err; counter cleared. Reset mid-transaction abandons it: no further
//    mem_re/mem_we, and late mem_rdata is ignored.
//  - States: IDLE, ACK, ISSUE_HI, WAIT, RD_DONE, WR_DONE.
//  - IDLE: samples read|write at each edge. The request (addr, wdata, type) is
//    latched at acceptance. The cpu holds the request until cack.
//    read&write together: treated as write.
//  - ACK (1 cycle): cack=1, busy=1.
//      data read:  mem_re=1, mem_addr={2'b00,addr}.
//      data write: mem_we=1, mem_addr={2'b00,addr}, mem_wdata=wdata; next WR_DONE.
//      instr read: mem_re=1, mem_addr={1'b1,addr,1'b0}; next ISSUE_HI.
//      instr write: no strobe; err<=1; next WR_DONE.
//      Any read otherwise goes to WAIT.
//  - ISSUE_HI (1 cycle): busy=1, mem_re=1, mem_addr={1'b1,addr,1'b1}; next WAIT.
//  - WAIT: busy=1.
//      Counter captures mem_rdata exactly LATENCY cycles after each mem_re.
//      Data read: into mem_bus.
//      Instr read: low half into instr[15:0], high half into instr[31:16].
//      After the last capture, next state is RD_DONE.
//  - Read timing (request sampled end of cycle 0):
//      data read: RD_DONE from cycle 2+LATENCY.
//      instr read: RD_DONE from cycle 3+LATENCY.
//  - RD_DONE: ready=1, busy=0. Held until read_done is sampled 1, then IDLE.
//    read/write are not accepted in RD_DONE.
//  - WR_DONE (1 cycle, cycle 2): ready=1, busy=0; then IDLE.
//    A new request can be sampled at the end of cycle 3.
//  - mem_bus and instr keep their last captured value until overwritten.
//    An instr fetch never alters mem_bus, and vice versa.
//  - Requests arriving while not in IDLE are ignored (not queued).
//  - mem_we and mem_re are never high in the same cycle.
//  - err is cleared only by rst.
// TESTING (LATENCY=2)
//  1 Data write addr=0x0010 wdata=0xBEEF -> cycle1 cack=1, mem_we=1,
//    mem_addr=0x00010; cycle2 ready=1; cycle3 busy=0, ready=0.
//  2 Data read addr=0x0010 after test 1 -> cycle1 mem_re; cycles1-3 busy=1;
//    cycle4 ready=1, mem_bus=0xBEEF; ready held through 5 idle cycles until
//    read_done=1.
//  3 Instr read addr=0x0003, RAM[0x20006]=0x1234, RAM[0x20007]=0xABCD ->
//    mem_re cycles 1,2 at 0x20006/0x20007; cycle5 ready=1, instr=0xABCD1234;
//    mem_bus unchanged.
//  4 read=write=1 addr=0x0001 wdata=0x5555 -> treated as write; no mem_re;
//    RAM[0x00001]=0x5555.
//  5 instr_access=1, write=1 -> cack, then ready pulse; mem_we stays 0;
//    err=1 and stays 1 through later traffic.
//  6 rst pulsed in WAIT of a data read -> all outputs 0 at once; later
//    mem_rdata not captured; next read completes normally.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-bus target: turns cpu data reads/writes and 32-bit instruction fetches
// into strobes on a pipelined 16-bit synchronous RAM and returns handshake plus data.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int MEM_AW  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  input  logic              read,
  input  logic              write,
  input  logic              instr_access,
  input  logic              read_done,
  output logic [15:0]       mem_bus,
  output logic [31:0]       instr,
  output logic              busy,
  output logic              cack,
  output logic              ready,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACK, ST_ISSUE_HI, ST_WAIT, ST_RD_DONE, ST_WR_DONE
  } state_t;

  state_t              r_state;
  logic [15:0]         r_addr;
  logic                r_is_wr;
  logic                r_is_instr;
  logic                r_cap_cnt;
  logic [LATENCY-1:0]  r_re_pipe;
  logic [15:0]         r_mem_bus;
  logic [31:0]         r_instr;
  logic                r_busy;
  logic                r_cack;
  logic                r_ready;
  logic                r_err;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_re;

  logic                w_cap;
  logic                w_last;

  // r_re_pipe[k] holds mem_re from k+1 cycles ago, so the top bit marks valid rdata
  assign w_cap  = r_re_pipe[LATENCY-1];
  assign w_last = !r_is_instr || r_cap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_is_instr  <= 1'b0;
      r_cap_cnt   <= 1'b0;
      r_re_pipe   <= '0;
      r_mem_bus   <= '0;
      r_instr     <= '0;
      r_busy      <= 1'b0;
      r_cack      <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_re_pipe[0] <= r_mem_re;
      for (int i = 1; i < LATENCY; i++) r_re_pipe[i] <= r_re_pipe[i-1];

      if (w_cap) begin
        if (!r_is_instr)     r_mem_bus      <= mem_rdata;
        else if (!r_cap_cnt) r_instr[15:0]  <= mem_rdata;
        else                 r_instr[31:16] <= mem_rdata;
        r_cap_cnt <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (read || write) begin
            r_state    <= ST_ACK;
            r_addr     <= addr;
            r_is_wr    <= write;
            r_is_instr <= instr_access;
            r_cap_cnt  <= 1'b0;
            r_cack     <= 1'b1;
            r_busy     <= 1'b1;
            r_mem_we   <= write && !instr_access;
            r_mem_re   <= !write;
            r_mem_addr <= instr_access ? {1'b1, addr, 1'b0} : {2'b00, addr};
            if (write && !instr_access) r_mem_wdata <= wdata;
          end
        end
        ST_ACK: begin
          r_cack   <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_is_wr) begin
            r_state  <= ST_WR_DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_mem_re <= 1'b0;
            if (r_is_instr) r_err <= 1'b1;
          end else if (r_is_instr) begin
            r_state    <= ST_ISSUE_HI;
            r_mem_re   <= 1'b1;
            r_mem_addr <= {1'b1, r_addr, 1'b1};
          end else begin
            r_state  <= ST_WAIT;
            r_mem_re <= 1'b0;
          end
        end
        ST_ISSUE_HI: begin
          r_mem_re <= 1'b0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_cap && w_last) begin
            r_state <= ST_RD_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        ST_RD_DONE: begin
          if (read_done) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        end
        ST_WR_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_bus   = r_mem_bus;
  assign instr     = r_instr;
  assign busy      = r_busy;
  assign cack      = r_cack;
  assign ready     = r_ready;
  assign err       = r_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a two-cycle pipelined RAM model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata;
  logic        read, write, instr_access, read_done;
  logic [15:0] mem_bus;
  logic [31:0] instr;
  logic        busy, cack, ready, err;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // RAM model: read data appears two cycles after the mem_re cycle
  logic [15:0] ram [0:262143];
  logic [15:0] rd_p1, rd_p2;
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_p1 <= mem_re ? ram[mem_addr] : 16'h0000;
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  mem_responder #(.LATENCY(2), .MEM_AW(18)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .instr_access(instr_access), .read_done(read_done), .mem_bus(mem_bus),
    .instr(instr), .busy(busy), .cack(cack), .ready(ready), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; read = 0; write = 0;
    instr_access = 0; read_done = 0;
    pre_we = 1'b1; pre_addr = 18'h20006; pre_data = 16'h1234;
    rd_p1 = '0; rd_p2 = '0;
    tick();
    pre_addr = 18'h20007; pre_data = 16'hABCD;
    tick();
    pre_we = 1'b0;
    tick();
    chk("rst_busy", busy, 0);   chk("rst_cack", cack, 0);
    chk("rst_ready", ready, 0); chk("rst_err", err, 0);
    chk("rst_bus", mem_bus, 0); chk("rst_instr", instr, 0);
    chk("rst_we", mem_we, 0);   chk("rst_re", mem_re, 0);
    chk("rst_maddr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Test 1: data write
    addr = 16'h0010; wdata = 16'hBEEF; write = 1;
    tick();
    chk("t1_c1_cack", cack, 1); chk("t1_c1_we", mem_we, 1); chk("t1_c1_re", mem_re, 0);
    chk("t1_c1_maddr", mem_addr, 32'h00010); chk("t1_c1_wdata", mem_wdata, 16'hBEEF);
    chk("t1_c1_busy", busy, 1);
    write = 0;
    tick();
    chk("t1_c2_ready", ready, 1); chk("t1_c2_busy", busy, 0);
    chk("t1_c2_cack", cack, 0);   chk("t1_c2_we", mem_we, 0);
    tick();
    chk("t1_c3_busy", busy, 0); chk("t1_c3_ready", ready, 0);

    // Test 2: data read back
    addr = 16'h0010; read = 1;
    tick();
    chk("t2_c1_re", mem_re, 1); chk("t2_c1_maddr", mem_addr, 32'h00010);
    chk("t2_c1_busy", busy, 1); chk("t2_c1_cack", cack, 1);
    read = 0;
    tick();
    chk("t2_c2_busy", busy, 1); chk("t2_c2_re", mem_re, 0); chk("t2_c2_ready", ready, 0);
    tick();
    chk("t2_c3_busy", busy, 1); chk("t2_c3_ready", ready, 0);
    tick();
    chk("t2_c4_ready", ready, 1); chk("t2_c4_busy", busy, 0);
    chk("t2_c4_bus", mem_bus, 16'hBEEF);
    write = 1; addr = 16'h0002; wdata = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_ready", ready, 1);
      chk("t2_hold_cack", cack, 0);
    end
    write = 0; read_done = 1;
    tick();
    chk("t2_done_ready", ready, 0); chk("t2_done_busy", busy, 0);
    read_done = 0;

    // Test 3: instruction fetch
    instr_access = 1; read = 1; addr = 16'h0003;
    tick();
    chk("t3_c1_re", mem_re, 1); chk("t3_c1_maddr", mem_addr, 32'h20006); chk("t3_c1_cack", cack, 1);
    read = 0;
    tick();
    chk("t3_c2_re", mem_re, 1); chk("t3_c2_maddr", mem_addr, 32'h20007);
    chk("t3_c2_cack", cack, 0); chk("t3_c2_busy", busy, 1);
    tick();
    chk("t3_c3_re", mem_re, 0); chk("t3_c3_busy", busy, 1);
    tick();
    chk("t3_c4_busy", busy, 1); chk("t3_c4_ready", ready, 0);
    tick();
    chk("t3_c5_ready", ready, 1); chk("t3_c5_instr", instr, 32'hABCD1234);
    chk("t3_c5_bus", mem_bus, 16'hBEEF);
    read_done = 1;
    tick();
    read_done = 0; instr_access = 0;
    chk("t3_done_ready", ready, 0);

    // Test 4: read and write together act as a write
    read = 1; write = 1; addr = 16'h0001; wdata = 16'h5555;
    tick();
    chk("t4_c1_we", mem_we, 1); chk("t4_c1_re", mem_re, 0); chk("t4_c1_maddr", mem_addr, 32'h00001);
    read = 0; write = 0;
    tick();
    chk("t4_c2_ready", ready, 1); chk("t4_c2_re", mem_re, 0);
    tick();
    chk("t4_ram", ram[1], 16'h5555);

    // Test 5: instruction-space write raises sticky err
    instr_access = 1; write = 1; addr = 16'h0005; wdata = 16'h7777;
    tick();
    chk("t5_c1_cack", cack, 1); chk("t5_c1_we", mem_we, 0); chk("t5_c1_re", mem_re, 0);
    write = 0; instr_access = 0;
    tick();
    chk("t5_c2_ready", ready, 1); chk("t5_c2_we", mem_we, 0); chk("t5_c2_err", err, 1);
    tick();
    chk("t5_c3_ready", ready, 0); chk("t5_ram", ram[18'h2000A], 16'h0000);
    addr = 16'h0001; read = 1;
    tick();
    read = 0;
    tick(); tick(); tick();
    chk("t5_rd_ready", ready, 1); chk("t5_rd_bus", mem_bus, 16'h5555);
    chk("t5_rd_instr", instr, 32'hABCD1234); chk("t5_err_sticky", err, 1);
    read_done = 1;
    tick();
    read_done = 0;

    // Test 6: reset during WAIT of a data read
    addr = 16'h0010; read = 1;
    tick();
    read = 0;
    tick();
    chk("t6_wait_busy", busy, 1);
    rst = 1;
    #1;
    chk("t6_rst_busy", busy, 0); chk("t6_rst_err", err, 0);
    chk("t6_rst_bus", mem_bus, 0); chk("t6_rst_instr", instr, 0);
    chk("t6_rst_re", mem_re, 0);
    rst = 0;
    tick();
    tick();
    chk("t6_late_bus", mem_bus, 0); chk("t6_late_ready", ready, 0);
    chk("t6_late_busy", busy, 0); chk("t6_late_re", mem_re, 0);
    addr = 16'h0010; read = 1;
    tick();
    chk("t6_rd_cack", cack, 1);
    read = 0;
    tick(); tick(); tick();
    chk("t6_rd_ready", ready, 1); chk("t6_rd_bus", mem_bus, 16'hBEEF);
    read_done = 1;
    tick();
    read_done = 0;
    chk("t6_rd_idle", ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
